biriscv_alu_pipe: RTL and testbench
===================================

BIRISCV_ALU_PIPE -- requirements
Module: biriscv_alu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter SHIFT_STEP, default 0, shift bits per cycle; 0 = single-cycle barrel shift; legal 1, 2, 4, 8 = iterative shift.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard in-flight operation.
REQ-006 SHALL have port valid_i  input  1  operation request.
REQ-007 SHALL have port ready_o  output  1  block can accept a request.
REQ-008 SHALL have port alu_op_i  input  4  opcode.
REQ-009 SHALL have ports alu_a_i and alu_b_i  input  XLEN  operands.
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  consumer takes result.
REQ-012 SHALL have port alu_p_o  output  XLEN  result.
REQ-013 SHALL have port zero_o  output  1  alu_p_o equals zero.

Function
REQ-014 Opcodes SHALL be: NONE 0, SHIFTL 1, SHIFTR 2, SHIFTR_ARITH 3, ADD 4, SUB 6, AND 7, OR 8, XOR 9, LESS_THAN 10, LESS_THAN_SIGNED 11, ROTL 12, ROTR 13.
REQ-015 NONE and unlisted codes SHALL return alu_a_i unchanged.
REQ-016 Shift and rotate amount SHALL be alu_b_i[log2(XLEN)-1:0]; upper bits are ignored.
REQ-017 ADD and SUB SHALL wrap modulo 2^XLEN; compares SHALL return 1 or 0, zero-extended to XLEN.
REQ-018 SHIFTR_ARITH SHALL fill with alu_a_i[XLEN-1]; ROTL and ROTR SHALL wrap bits end-around.
REQ-019 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-020 A request SHALL be accepted on a cycle where valid_i && ready_o && !flush_i; operands and opcode are captured.
REQ-021 ready_o SHALL equal (state==IDLE) || (state==DONE && ready_i).
REQ-022 On accept of a non-shift op, or any op when SHIFT_STEP=0, the result SHALL be registered and the FSM SHALL enter DONE; latency is 1 cycle.
REQ-023 On accept of a shift or rotate with SHIFT_STEP>0 and amount N>0, the FSM SHALL enter SHIFT.
REQ-024 In SHIFT, each cycle SHALL shift by min(SHIFT_STEP, remaining), for ceil(N/SHIFT_STEP) cycles; the last step SHALL enter DONE; total latency is ceil(N/SHIFT_STEP)+1.
REQ-025 A shift with N=0 SHALL go straight to DONE with alu_p_o = alu_a_i.
REQ-026 In DONE, valid_o SHALL be 1; alu_p_o and zero_o SHALL hold stable until ready_i.
REQ-027 On DONE && ready_i: if a new request is accepted the same cycle, the FSM SHALL take the REQ-022/023 path; otherwise it SHALL go to IDLE with valid_o 0 next cycle.
REQ-028 flush_i SHALL take priority over every other event: next state IDLE, valid_o 0 next cycle, no request accepted that cycle, no result produced.
REQ-029 Operand inputs SHALL be ignored while not accepting; captured values are used.

Reset
REQ-030 While rst_ni is low, the block SHALL be in IDLE with valid_o 0, alu_p_o 0, zero_o 0 and the internal shift count 0.
REQ-031 Reset asserted mid-operation SHALL drop valid_o and clear outputs asynchronously; no result from before reset SHALL appear.
REQ-032 ready_o SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 ADD, a=0xFFFFFFFF, b=0x1, ready_i=1 -> valid_o one cycle after accept, alu_p_o=0x0, zero_o=1.
REQ-034 SHIFT_STEP=4, SHIFTR_ARITH, a=0x80000000, b=0x3F -> amount 31, valid_o 9 cycles after accept, alu_p_o=0xFFFFFFFF.
REQ-035 SHIFT_STEP=0: ROTR a=0x1, b=0x1 -> 0x80000000 at latency 1; LESS_THAN_SIGNED a=0xFFFFFFFF, b=0x1 -> 0x1; LESS_THAN on the same operands -> 0x0.
REQ-036 ready_i low for 3 cycles in DONE -> alu_p_o stable, ready_o 0; a second valid_i is accepted in the cycle ready_i rises, and its result follows back-to-back.
REQ-037 SHIFT_STEP=1, SHIFTL b=16, flush_i pulsed on the 5th SHIFT cycle -> valid_o never asserts, ready_o=1 the next cycle; repeating with rst_ni low instead -> alu_p_o=0 immediately.
REQ-038 XLEN=64, SHIFTL a=0x1, b=0x7F -> alu_p_o=0x8000000000000000.

Source files
------------

// File: rtl/biriscv_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | biriscv_alu_pipe : registered ALU with valid/ready handshake and optional  |
// |                    iterative shifter (SHIFT_STEP bits per cycle)           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module biriscv_alu_pipe #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_p_o,
  output logic            zero_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_SHIFTL       = 4'd1;
  localparam logic [3:0] OP_SHIFTR       = 4'd2;
  localparam logic [3:0] OP_SHIFTR_ARITH = 4'd3;
  localparam logic [3:0] OP_ADD          = 4'd4;
  localparam logic [3:0] OP_SUB          = 4'd6;
  localparam logic [3:0] OP_AND          = 4'd7;
  localparam logic [3:0] OP_OR           = 4'd8;
  localparam logic [3:0] OP_XOR          = 4'd9;
  localparam logic [3:0] OP_LESS_THAN    = 4'd10;
  localparam logic [3:0] OP_LESS_THAN_S  = 4'd11;
  localparam logic [3:0] OP_ROTL         = 4'd12;
  localparam logic [3:0] OP_ROTR         = 4'd13;

  localparam logic [SHW-1:0] STEP_AMT = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHIFTL) || (op == OP_SHIFTR) || (op == OP_SHIFTR_ARITH) ||
           (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

  // Rotates take the matching half of the operand concatenated with itself.
  function automatic logic [XLEN-1:0] shift_op(input logic [3:0]      op,
                                               input logic [XLEN-1:0] val,
                                               input logic [SHW-1:0]  amt);
    logic [2*XLEN-1:0] dbl;
    logic [XLEN-1:0]   res;
    dbl = {val, val};
    res = val;
    case (op)
      OP_SHIFTL:       res = val << amt;
      OP_SHIFTR:       res = val >> amt;
      OP_SHIFTR_ARITH: res = $unsigned($signed(val) >>> amt);
      OP_ROTL: begin
        dbl = dbl << amt;
        res = dbl[2*XLEN-1:XLEN];
      end
      OP_ROTR: begin
        dbl = dbl >> amt;
        res = dbl[XLEN-1:0];
      end
      default: res = val;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0]      op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    case (op)
      OP_ADD:         res = a + b;
      OP_SUB:         res = a - b;
      OP_AND:         res = a & b;
      OP_OR:          res = a | b;
      OP_XOR:         res = a ^ b;
      OP_LESS_THAN:   res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_LESS_THAN_S: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHIFTL, OP_SHIFTR, OP_SHIFTR_ARITH, OP_ROTL, OP_ROTR:
                      res = shift_op(op, a, b[SHW-1:0]);
      default:        res = a;
    endcase
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic            accept_w;
  logic [SHW-1:0]  step_w;
  logic [XLEN-1:0] shifted_w;

  assign ready_o   = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
  assign accept_w  = valid_i && ready_o && !flush_i;
  assign step_w    = (cnt_q > STEP_AMT) ? STEP_AMT : cnt_q;
  assign shifted_w = shift_op(op_q, work_q, step_w);

  assign valid_o = (state_q == S_DONE);
  assign alu_p_o = result_q;
  assign zero_o  = zero_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept_w) begin
      if ((SHIFT_STEP != 0) && is_shift(alu_op_i) && (alu_b_i[SHW-1:0] != '0)) begin
        state_d = S_SHIFT;
        op_d    = alu_op_i;
        work_d  = alu_a_i;
        cnt_d   = alu_b_i[SHW-1:0];
      end else begin
        state_d  = S_DONE;
        result_d = alu_fn(alu_op_i, alu_a_i, alu_b_i);
        zero_d   = (result_d == '0);
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          work_d = shifted_w;
          cnt_d  = cnt_q - step_w;
          // Final partial step lands the result and releases the handshake.
          if (cnt_q == step_w) begin
            state_d  = S_DONE;
            result_d = shifted_w;
            zero_d   = (shifted_w == '0);
          end
        end
        S_DONE: begin
          if (ready_i) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biriscv_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_biriscv_alu_pipe : four ALU configurations checked against a result and |
// |                       latency model plus directed literal expectations     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_biriscv_alu_pipe;

  localparam logic [3:0] OP_NONE = 4'd0,  OP_SHL = 4'd1,  OP_SHR  = 4'd2,  OP_SRA  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4,  OP_SUB = 4'd6,  OP_AND  = 4'd7,  OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9,  OP_LT  = 4'd10, OP_LTS  = 4'd11, OP_ROTL = 4'd12;
  localparam logic [3:0] OP_ROTR = 4'd13;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        v_in[4], rdy_in[4], fl_in[4];
  logic [3:0]  op_in[4];
  logic [63:0] a_in[4], b_in[4];
  logic        rdy_o[4], v_o[4], z_o[4];
  logic [31:0] p32[3];
  logic [63:0] p64;

  int total = 0;
  int bad   = 0;

  biriscv_alu_pipe #(.XLEN(32), .SHIFT_STEP(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_in[0]), .valid_i(v_in[0]), .ready_o(rdy_o[0]),
    .alu_op_i(op_in[0]), .alu_a_i(a_in[0][31:0]), .alu_b_i(b_in[0][31:0]),
    .valid_o(v_o[0]), .ready_i(rdy_in[0]), .alu_p_o(p32[0]), .zero_o(z_o[0]));
  biriscv_alu_pipe #(.XLEN(32), .SHIFT_STEP(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_in[1]), .valid_i(v_in[1]), .ready_o(rdy_o[1]),
    .alu_op_i(op_in[1]), .alu_a_i(a_in[1][31:0]), .alu_b_i(b_in[1][31:0]),
    .valid_o(v_o[1]), .ready_i(rdy_in[1]), .alu_p_o(p32[1]), .zero_o(z_o[1]));
  biriscv_alu_pipe #(.XLEN(32), .SHIFT_STEP(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_in[2]), .valid_i(v_in[2]), .ready_o(rdy_o[2]),
    .alu_op_i(op_in[2]), .alu_a_i(a_in[2][31:0]), .alu_b_i(b_in[2][31:0]),
    .valid_o(v_o[2]), .ready_i(rdy_in[2]), .alu_p_o(p32[2]), .zero_o(z_o[2]));
  biriscv_alu_pipe #(.XLEN(64), .SHIFT_STEP(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_in[3]), .valid_i(v_in[3]), .ready_o(rdy_o[3]),
    .alu_op_i(op_in[3]), .alu_a_i(a_in[3]), .alu_b_i(b_in[3]),
    .valid_o(v_o[3]), .ready_i(rdy_in[3]), .alu_p_o(p64), .zero_o(z_o[3]));

  function automatic int step_of(input int k);
    case (k)
      0: return 0;
      1: return 4;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int xlen_of(input int k);
    return (k == 3) ? 64 : 32;
  endfunction

  function automatic logic [63:0] p_of(input int k);
    case (k)
      0: return {32'b0, p32[0]};
      1: return {32'b0, p32[1]};
      2: return {32'b0, p32[2]};
      default: return p64;
    endcase
  endfunction

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a_raw,
                                          input logic [63:0] b_raw, input int xl);
    logic [63:0] mask, a, b, sb, r;
    int n;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    a  = a_raw & mask;
    b  = b_raw & mask;
    sb = 64'd1 << (xl - 1);
    n  = int'(b & 64'(xl - 1));
    case (op)
      OP_SHL:  r = a << n;
      OP_SHR:  r = a >> n;
      OP_SRA: begin
        r = a >> n;
        if ((a & sb) != 0) r = r | ~(mask >> n);
      end
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_LT:   r = (a < b) ? 64'd1 : 64'd0;
      OP_LTS:  r = ((a ^ sb) < (b ^ sb)) ? 64'd1 : 64'd0;
      OP_ROTL: r = (n == 0) ? a : ((a << n) | (a >> (xl - n)));
      OP_ROTR: r = (n == 0) ? a : ((a >> n) | (a << (xl - n)));
      default: r = a;
    endcase
    return r & mask;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] b, input int k);
    int s, n;
    logic sh;
    s  = step_of(k);
    n  = int'(b & 64'(xlen_of(k) - 1));
    sh = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA) || (op == OP_ROTL) || (op == OP_ROTR);
    if (s == 0 || !sh || n == 0) return 1;
    return (n + s - 1) / s + 1;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Model: pending result with a countdown of remaining busy cycles, and a held output.
  logic        m_busy[4], m_have[4], m_zero[4];
  int          m_cnt[4];
  logic [63:0] m_pend[4], m_res[4];

  always @(posedge clk or negedge rst_n) begin : p_model
    logic        rdy_m;
    int          lat_m;
    logic [63:0] r_m;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_busy[k] <= 1'b0; m_have[k] <= 1'b0; m_zero[k] <= 1'b0;
        m_cnt[k]  <= 0;    m_pend[k] <= '0;   m_res[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        rdy_m = !m_busy[k] && (!m_have[k] || rdy_in[k]);
        if (fl_in[k]) begin
          m_busy[k] <= 1'b0;
          m_have[k] <= 1'b0;
        end else if (rdy_m && v_in[k]) begin
          r_m   = ref_alu(op_in[k], a_in[k], b_in[k], xlen_of(k));
          lat_m = ref_lat(op_in[k], b_in[k], k);
          if (lat_m == 1) begin
            m_busy[k] <= 1'b0; m_have[k] <= 1'b1; m_res[k] <= r_m; m_zero[k] <= (r_m == 0);
          end else begin
            m_busy[k] <= 1'b1; m_have[k] <= 1'b0; m_cnt[k] <= lat_m - 1; m_pend[k] <= r_m;
          end
        end else if (m_busy[k]) begin
          if (m_cnt[k] == 1) begin
            m_busy[k] <= 1'b0; m_have[k] <= 1'b1; m_res[k] <= m_pend[k]; m_zero[k] <= (m_pend[k] == 0);
          end else begin
            m_cnt[k] <= m_cnt[k] - 1;
          end
        end else if (m_have[k] && rdy_in[k]) begin
          m_have[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        chk("rst_valid", k, 64'(v_o[k]), 64'd0);
        chk("rst_result", k, p_of(k), 64'd0);
        chk("rst_zero", k, 64'(z_o[k]), 64'd0);
      end else begin
        chk("valid", k, 64'(v_o[k]), 64'(m_have[k]));
        chk("ready", k, 64'(rdy_o[k]), 64'(!m_busy[k] && (!m_have[k] || rdy_in[k])));
        chk("result", k, p_of(k), m_res[k]);
        chk("zero", k, 64'(z_o[k]), 64'(m_zero[k]));
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int k, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic ok;
    ok = 1'b0;
    v_in[k] = 1'b1; op_in[k] = op; a_in[k] = a; b_in[k] = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_o[k];
      @(posedge clk);
      #1;
    end
    v_in[k] = 1'b0; a_in[k] = ~a; b_in[k] = ~b;
    chk("accept", k, 64'(ok), 64'd1);
  endtask

  task automatic wait_res(input int k, input int exp_lat, input logic [63:0] exp_val, input string name);
    int lat;
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (v_o[k]) begin
        lat = i;
        break;
      end
    end
    chk({name, "_lat"}, k, 64'(lat), 64'(exp_lat));
    chk(name, k, p_of(k), exp_val);
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  t_op[15] = '{OP_ADD, OP_ROTR, OP_LTS, OP_LT, OP_SUB, OP_AND, OP_OR, OP_XOR,
                            OP_SHL, OP_SHR, OP_SRA, OP_ROTL, OP_NONE, 4'd5, 4'd15};
  logic [31:0] t_a[15]  = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'hF0F0_1234,
                            32'hF0F0_0000, 32'hAAAA_5555, 32'h3, 32'h8000_0000, 32'h8000_0010,
                            32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
  logic [31:0] t_b[15]  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7, 32'h0FF0_FF00, 32'h0F0F_00FF,
                            32'hFFFF_0000, 32'h21, 32'h4, 32'h4, 32'h4, 32'h1, 32'h1, 32'h7};
  logic [31:0] t_exp[15] = '{32'h0, 32'h8000_0000, 32'h1, 32'h0, 32'hFFFF_FFFE, 32'h00F0_1200,
                             32'hFFFF_00FF, 32'h5555_5555, 32'h6, 32'h0800_0000, 32'hF800_0001,
                             32'h0000_0018, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};

  initial begin
    logic seen;
    for (int k = 0; k < 4; k++) begin
      v_in[k] = 1'b0; rdy_in[k] = 1'b1; fl_in[k] = 1'b0;
      op_in[k] = 4'd0; a_in[k] = '0; b_in[k] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("ready_after_rst", k, 64'(rdy_o[k]), 64'd1);
    @(posedge clk);
    #1;

    chk("mdl_add", 0, ref_alu(OP_ADD, 64'hFFFF_FFFF, 64'h1, 32), 64'h0);
    chk("mdl_sra", 0, ref_alu(OP_SRA, 64'h8000_0000, 64'h3F, 32), 64'hFFFF_FFFF);
    chk("mdl_rotr", 0, ref_alu(OP_ROTR, 64'h1, 64'h1, 32), 64'h8000_0000);
    chk("mdl_lts", 0, ref_alu(OP_LTS, 64'hFFFF_FFFF, 64'h1, 32), 64'h1);
    chk("mdl_lt", 0, ref_alu(OP_LT, 64'hFFFF_FFFF, 64'h1, 32), 64'h0);
    chk("mdl_shl64", 3, ref_alu(OP_SHL, 64'h1, 64'h7F, 64), 64'h8000_0000_0000_0000);
    chk("mdl_lat", 1, 64'(ref_lat(OP_SRA, 64'h3F, 1)), 64'd9);

    for (int i = 0; i < 15; i++) begin
      issue(0, t_op[i], {32'b0, t_a[i]}, {32'b0, t_b[i]});
      wait_res(0, 1, {32'b0, t_exp[i]}, "k0_res");
      chk("k0_zero", 0, 64'(z_o[0]), 64'(t_exp[i] == 32'h0));
    end

    // Consumer stalls three cycles; next request rides the cycle ready_i returns.
    rdy_in[0] = 1'b0;
    issue(0, OP_ADD, 64'h2, 64'h3);
    wait_res(0, 1, 64'h5, "bp_first");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", 0, p_of(0), 64'h5);
      chk("bp_ready", 0, 64'(rdy_o[0]), 64'd0);
      chk("bp_valid", 0, 64'(v_o[0]), 64'd1);
    end
    @(posedge clk);
    #1;
    rdy_in[0] = 1'b1;
    issue(0, OP_XOR, 64'hF0, 64'h0F);
    wait_res(0, 1, 64'hFF, "bp_second");

    issue(1, OP_SRA, 64'h8000_0000, 64'h3F);
    wait_res(1, 9, 64'hFFFF_FFFF, "k1_sra");
    issue(1, OP_SHL, 64'h1234, 64'h20);
    wait_res(1, 1, 64'h1234, "k1_shl0");
    issue(1, OP_ROTL, 64'h8000_0001, 64'h5);
    wait_res(1, 3, 64'h30, "k1_rotl");
    issue(1, OP_ADD, 64'h7, 64'h8);
    wait_res(1, 1, 64'hF, "k1_add");
    issue(1, OP_ROTR, 64'hF0, 64'h8);
    wait_res(1, 3, 64'hF000_0000, "k1_rotr");
    issue(1, OP_SHR, 64'hFFFF_FFFF, 64'h1);
    wait_res(1, 2, 64'h7FFF_FFFF, "k1_shr");

    issue(2, OP_ADD, 64'h1234, 64'h0);
    wait_res(2, 1, 64'h1234, "k2_add");
    issue(2, OP_SHL, 64'h1, 64'd16);
    repeat (4) @(posedge clk);
    #1;
    fl_in[2] = 1'b1;
    @(posedge clk);
    #1;
    fl_in[2] = 1'b0;
    @(negedge clk);
    chk("flush_ready", 2, 64'(rdy_o[2]), 64'd1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (v_o[2]) seen = 1'b1;
    end
    chk("flush_no_valid", 2, 64'(seen), 64'd0);
    chk("flush_keeps_p", 2, p_of(2), 64'h1234);
    @(posedge clk);
    #1;

    issue(2, OP_SHL, 64'h1, 64'd16);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_p", 2, p_of(2), 64'h0);
    chk("arst_valid", 2, 64'(v_o[2]), 64'd0);
    chk("arst_zero", 2, 64'(z_o[2]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (v_o[2]) seen = 1'b1;
    end
    chk("arst_no_valid", 2, 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    issue(3, OP_SHL, 64'h1, 64'h7F);
    wait_res(3, 33, 64'h8000_0000_0000_0000, "k3_shl");
    issue(3, OP_SRA, 64'h8000_0000_0000_0000, 64'h3);
    wait_res(3, 3, 64'hF000_0000_0000_0000, "k3_sra");
    issue(3, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2);
    wait_res(3, 1, 64'h1, "k3_add");
    issue(3, OP_ROTR, 64'h1, 64'h41);
    wait_res(3, 2, 64'h8000_0000_0000_0000, "k3_rotr");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
